// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display blocks: display-word layout,
// idle levels and segment bit positions.
package disp_pkg;

  localparam int DISP_W = 24;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_word_t;

  localparam logic [7:0] LED_OFF = 8'hFF;
  localparam logic [3:0] SA_OFF  = 4'bzzzz;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order g..a (bit 0 = a).
module hex7seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    unique case (i_nib)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/led7seg_scan.sv
// 4-digit multiplexed 7-segment scanner with per-slot blanking and a
// double-buffered display word committed only at frame boundaries.
module led7seg_scan
  import disp_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter int BLANK = 50
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic [3:0]  EN,
  input  logic        UPD,
  output logic        ACK,
  output logic        FRAME,
  output logic [7:0]  LED,
  output wire  [3:0]  SA
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_idx;
  disp_word_t       r_stage;
  disp_word_t       r_shadow;
  logic             r_pending;
  logic             r_ack;

  logic             w_slot_end;
  logic             w_frame;
  logic             w_drive;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic [DISP_W-1:0] w_upd_word;

  assign w_upd_word = {DATA, DP, EN};
  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_frame    = w_slot_end && (r_idx == 2'd3);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_stage   <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end)
        r_idx <= r_idx + 2'd1;
      r_ack <= 1'b0;
      // A strobe on the boundary edge takes priority: the fresh value is
      // staged and the commit waits for the next frame boundary.
      if (UPD) begin
        r_stage   <= disp_word_t'(w_upd_word);
        r_pending <= 1'b1;
      end else if (w_frame && r_pending) begin
        r_shadow  <= r_stage;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end
    end
  end

  assign w_nib   = r_shadow.data[{r_idx, 2'b00} +: 4];
  assign w_drive = (r_cnt >= CNT_BLANK) && r_shadow.en[r_idx];

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_comb begin
    LED = LED_OFF;
    if (w_drive) begin
      LED[SEG_G:SEG_A] = w_seg;
      LED[SEG_DP]      = ~r_shadow.dp[r_idx];
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_anode
    assign SA[k] = (w_drive && (r_idx == 2'(k))) ? 1'b0 : SA_OFF[k];
  end

  assign ACK   = r_ack;
  assign FRAME = w_frame;

endmodule

// File: tb/tb_led7seg_scan.sv
// Scoreboard bench for led7seg_scan: stimulus queues expected commits,
// a negedge monitor checks ACK/FRAME/LED/SA against a frame-level model.
module tb_led7seg_scan;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRM   = 4 * DIV;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] DATA = '0;
  logic [3:0]  DP = '0;
  logic [3:0]  EN = '0;
  logic        UPD = 1'b0;
  logic        ACK;
  logic        FRAME;
  logic [7:0]  LED;
  wire  [3:0]  w_sa;

  for (genvar k = 0; k < 4; k++) begin : g_pull
    pullup (w_sa[k]);
  end

  led7seg_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .DATA  (DATA),
    .DP    (DP),
    .EN    (EN),
    .UPD   (UPD),
    .ACK   (ACK),
    .FRAME (FRAME),
    .LED   (LED),
    .SA    (w_sa)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  en;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc;
  logic [15:0] m_d  = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_en = '0;

  logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always @(posedge CLK or negedge RST_N)
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] driven_mask();
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = (w_sa[k] === 1'b0);
    return m;
  endfunction

  // ACK cycle for a strobe held during cycle t: commit at the first frame
  // boundary edge after t, skipping a boundary that coincides with the strobe.
  function automatic int ack_of(input int t);
    int b;
    b = (t % FRM == FRM - 1) ? t + FRM : t + (FRM - 1 - t % FRM);
    return b + 1;
  endfunction

  always @(negedge CLK) begin : mon
    int c, ph, slot;
    bit exp_ack;
    logic [7:0] e_led;
    logic [3:0] e_drv;
    exp_t e;
    if (RST_N) begin
      c = cyc;
      while (q.size() > 0 && q[0].cyc < c) begin
        e = q.pop_front();
        m_d = e.d; m_dp = e.dp; m_en = e.en;
      end
      exp_ack = (q.size() > 0) && (q[0].cyc == c);
      chk(ACK == exp_ack, "ack", 32'(ACK), 32'(exp_ack));
      if (exp_ack) begin
        e = q.pop_front();
        m_d = e.d; m_dp = e.dp; m_en = e.en;
      end
      chk(FRAME == (c % FRM == FRM - 1), "frame", 32'(FRAME), 32'(c % FRM == FRM - 1));
      ph   = c % DIV;
      slot = (c / DIV) % 4;
      e_led = 8'hFF;
      e_drv = 4'b0000;
      if (ph >= BLANK && m_en[slot]) begin
        e_led = {~m_dp[slot], HEX[m_d[slot*4 +: 4]]};
        e_drv = 4'(1 << slot);
      end
      chk(LED == e_led, "led", 32'(LED), 32'(e_led));
      chk(driven_mask() == e_drv, "sa_driven", 32'(driven_mask()), 32'(e_drv));
    end
  end

  task automatic wait_until(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (cyc != c) chk(1'b0, "schedule", 32'(cyc), 32'(c));
  endtask

  task automatic upd(input int c, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    wait_until(c);
    DATA = d; DP = dp; EN = en; UPD = 1'b1;
    @(posedge CLK); #1;
    UPD = 1'b0;
    DATA = 16'($urandom); DP = 4'($urandom); EN = 4'($urandom);
  endtask

  task automatic expect_commit(input int t, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    exp_t e;
    e.cyc = ack_of(t); e.d = d; e.dp = dp; e.en = en;
    q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, n, t0, t1, t2, last;
    logic [15:0] d;
    logic [3:0] dp, en;

    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // idle: blank display, FRAME every 32 cycles
    wait_until(64);

    upd(70, 16'h1234, 4'b0001, 4'b1111);
    expect_commit(70, 16'h1234, 4'b0001, 4'b1111);

    // two strobes in one frame: last wins, single ACK
    upd(135, 16'hABCD, 4'b0000, 4'b1111);
    upd(150, 16'hEF01, 4'b0000, 4'b1111);
    expect_commit(150, 16'hEF01, 4'b0000, 4'b1111);

    // strobe on the FRAME cycle defers the commit by one frame
    upd(191, 16'h5A3C, 4'b1010, 4'b1111);
    expect_commit(191, 16'h5A3C, 4'b1010, 4'b1111);

    upd(230, 16'h8888, 4'b0000, 4'b0101);
    expect_commit(230, 16'h8888, 4'b0000, 4'b0101);

    base = 256;
    for (int k = 0; k < 6; k++) begin
      n  = int'($urandom_range(1, 3));
      t0 = base + int'($urandom_range(0, 10));
      t1 = t0 + int'($urandom_range(1, 10));
      t2 = t1 + int'($urandom_range(1, 11));
      last = t0;
      d = 16'($urandom); dp = 4'($urandom); en = 4'($urandom);
      upd(t0, d, dp, en);
      if (n >= 2) begin
        d = 16'($urandom); dp = 4'($urandom); en = 4'($urandom);
        upd(t1, d, dp, en);
        last = t1;
      end
      if (n >= 3) begin
        d = 16'($urandom); dp = 4'($urandom); en = 4'($urandom);
        upd(t2, d, dp, en);
        last = t2;
      end
      expect_commit(last, d, dp, en);
      base = ack_of(last);
    end
    wait_until(base + 40);
    chk(q.size() == 0, "all_acks_seen", 32'(q.size()), 32'd0);

    // asynchronous reset mid-slot with an update pending
    base = cyc - (cyc % FRM) + FRM;
    upd(base + 5, 16'h7777, 4'b1111, 4'b1111);
    wait_until(base + 12);
    #3 RST_N = 1'b0;
    #1;
    chk(LED == 8'hFF, "reset_led", 32'(LED), 32'hFF);
    chk(driven_mask() == 4'b0000, "reset_sa", 32'(driven_mask()), 32'd0);
    q.delete();
    m_d = '0; m_dp = '0; m_en = '0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    wait_until(90);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
